// File: rtl/serial_adder16_pkg.sv
// Shared constants and FSM encoding for the bit-serial 16-bit adder.
// The state encodings are fixed so that waveform decoders and the ALU control agree on them.
package serial_adder16_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : serial_adder16_pkg

// File: rtl/serial_adder16_fa.sv
// m_FullAdder: single-bit full adder cell, purely combinational.
// Latency: zero cycles (sum and carry settle within the cycle).
// Backpressure: none; the serial adder drives it once per RUN cycle.
module m_FullAdder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_a ^ i_b ^ i_cin;
  assign o_carry = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);

endmodule : m_FullAdder

// File: rtl/serial_adder16.sv
// serial_adder16: bit-serial unsigned adder, one full-adder step per cycle, LSB first.
// Latency: o_done pulses in the cycle that begins WIDTH edges after the accepting edge.
// Backpressure: i_start is accepted only while o_ready=1; requests at other times are dropped.
// Optional: define SERIAL_ADDER16_OVF_EN to add the o_overflow (signed overflow) output.
module serial_adder16
  import serial_adder16_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic             o_ready,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
`ifdef SERIAL_ADDER16_OVF_EN
  output logic             o_overflow,
`endif
  output logic             o_carry
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q;
  logic [WIDTH-1:0] b_sr_q;
  logic [WIDTH-1:0] res_sr_q;
  logic [WIDTH-1:0] res_sr_d;
  logic             carry_q;
  logic [CNT_W-1:0] cnt_q;
  logic             ready_q;
  logic             done_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             fa_sum;
  logic             fa_carry;
`ifdef SERIAL_ADDER16_OVF_EN
  logic             ovf_q;
`endif

  m_FullAdder u_fa (
    .i_a     (a_sr_q[0]),
    .i_b     (b_sr_q[0]),
    .i_cin   (carry_q),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at position 0.
  assign res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};

  // Control FSM, datapath shift registers and registered outputs in one sequential block.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      res_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADDER16_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            a_sr_q  <= i_a;
            b_sr_q  <= i_b;
            carry_q <= i_cin;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          res_sr_q <= res_sr_d;
          a_sr_q   <= {1'b0, a_sr_q[WIDTH-1:1]};
          b_sr_q   <= {1'b0, b_sr_q[WIDTH-1:1]};
          carry_q  <= fa_carry;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            // Final step: carry_q is the carry into the MSB, fa_carry the carry out of it.
            sum_q   <= res_sr_d;
            cout_q  <= fa_carry;
`ifdef SERIAL_ADDER16_OVF_EN
            ovf_q   <= carry_q ^ fa_carry;
`endif
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_done  = done_q;
  assign o_sum   = sum_q;
  assign o_carry = cout_q;
`ifdef SERIAL_ADDER16_OVF_EN
  assign o_overflow = ovf_q;
`endif

endmodule : serial_adder16

// File: tb/tb_serial_adder16.sv
// Directed self-checking bench for serial_adder16 (16-bit default width).
// Inputs change on negedge or 1ns after posedge; outputs are sampled on negedge.
module tb_serial_adder16;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        ready;
  logic        done;
  logic [15:0] sum;
  logic        carry;
`ifdef SERIAL_ADDER16_OVF_EN
  logic        ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_adder16 dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_start (start),
    .i_a     (a),
    .i_b     (b),
    .i_cin   (cin),
    .o_ready (ready),
    .o_done  (done),
    .o_sum   (sum),
`ifdef SERIAL_ADDER16_OVF_EN
    .o_overflow (ovf),
`endif
    .o_carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive a request at a negedge and let the next posedge accept it.
  task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv, input bit hold);
    @(negedge clk);
    start = 1'b1;
    a     = av;
    b     = bv;
    cin   = cv;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Called just after the accepting edge; returns edges until o_done seen and ready-low cycles.
  task automatic wait_done(output int edges, output int low);
    edges = 0;
    low   = 0;
    @(negedge clk);
    if (!ready) low++;
    while (!done && edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (!ready) low++;
    end
  endtask

  int e, l, pulses, unstable;

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_done",  done,  0);
    chk("rst_sum",   sum,   16'h0000);
    chk("rst_carry", carry, 0);

    // 0x1234 + 0x4321: latency and ready-low window
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    wait_done(e, l);
    chk("lat_edges", e, 16);
    chk("lat_ready_low", l, 17);
    chk("add1_sum", sum, 16'h5555);
    chk("add1_carry", carry, 0);
`ifdef SERIAL_ADDER16_OVF_EN
    chk("add1_ovf", ovf, 0);
`endif
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("ready_back", ready, 1);
    chk("sum_hold", sum, 16'h5555);

    // Carry-out boundaries
    launch(16'h0001, 16'hFFFF, 1'b0, 1'b0);
    wait_done(e, l);
    chk("add2_edges", e, 16);
    chk("add2_sum", sum, 16'h0000);
    chk("add2_carry", carry, 1);
    launch(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    wait_done(e, l);
    chk("add3_sum", sum, 16'h0000);
    chk("add3_carry", carry, 1);

    // Start pulse during RUN must be ignored
    launch(16'h00FF, 16'h0001, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    start = 1'b1;
    a     = 16'hAAAA;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 16'h0000;
    wait_done(e, l);
    chk("ign_found_done", done, 1);
    chk("ign_sum", sum, 16'h0100);
    chk("ign_carry", carry, 0);
    @(negedge clk);
    chk("ign_no_requeue", ready, 1);

    // Reset mid-RUN aborts with no done pulse
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_done", done, 0);
    chk("abort_sum", sum, 16'h0000);
    chk("abort_ready", ready, 1);
    pulses = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("abort_no_pulse", pulses, 0);
    launch(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    wait_done(e, l);
    chk("restart_edges", e, 16);
    chk("restart_sum", sum, 16'h8000);
    chk("restart_carry", carry, 0);
`ifdef SERIAL_ADDER16_OVF_EN
    chk("restart_ovf", ovf, 1);
`endif

    // i_start held: back-to-back operations 18 cycles apart, output stable between
    launch(16'h0003, 16'h0004, 1'b0, 1'b1);
    wait_done(e, l);
    chk("hold1_edges", e, 16);
    chk("hold1_sum", sum, 16'h0007);
    e        = 0;
    unstable = 0;
    do begin
      @(posedge clk);
      e++;
      @(negedge clk);
      if (sum !== 16'h0007) unstable++;
    end while (!done && e < 40);
    start = 1'b0;
    chk("hold_gap", e, 18);
    chk("hold_stable", unstable, 0);
    chk("hold2_sum", sum, 16'h0007);
    chk("hold2_carry", carry, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_serial_adder16
